axis_stream_slave_mc: RTL and testbench

Multi-channel AXI4-Stream sink. It demultiplexes one incoming AXI4-Stream by TID into NUM_CH independent first-word-fall-through FIFOs, each with its own user-side valid/ready handshake. It stores TKEEP alongside data, counts stored beats and complete packets per channel, and counts beats dropped for out-of-range TIDs. It sits between the NoC/DMA stream fabric and the per-engine NPU input buffers.

---
 rtl/axis_stream_slave_mc.sv | 169 ++++++++++++++++
 tb/tb_axis_stream_slave_mc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_slave_mc.sv
// Purpose: AXI4-Stream sink that splits one input stream by TID into NUM_CH FWFT FIFOs.
//          Each FIFO stores {tdata,tkeep,tlast,tuser} and has its own valid/ready pop port.
// Latency: a beat accepted on one edge is visible at the channel head in the following cycle.
// Backpressure: a full target channel drops s_axis_tready for the whole input stream
//          (head-of-line blocking). Beats with TID >= NUM_CH are always accepted and counted
//          in a saturating drop counter.
// Ports:   clk/rst (sync active-high); s_axis_* input stream; rx_* per-channel head and pop
//          handshake, channel c at slice c; fifo_count/pkt_count per-channel occupancy and
//          stored-tlast counts; drop_count; fifo_full/fifo_empty per-channel flags.
// Option:  define AXIS_SLV_PKT_MODE_EN for store-and-forward. rx_valid is then held low
//          until a whole packet is stored, or until the FIFO is full (cut-through fallback).
module axis_stream_slave_mc #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH-1:0]                       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]                     s_axis_tkeep,
    input  logic                                        s_axis_tlast,
    input  logic [USER_WIDTH-1:0]                       s_axis_tuser,
    input  logic [ID_WIDTH-1:0]                         s_axis_tid,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0]                rx_data,
    output logic [NUM_CH*DATA_WIDTH/8-1:0]              rx_keep,
    output logic [NUM_CH-1:0]                           rx_last,
    output logic [NUM_CH*USER_WIDTH-1:0]                rx_user,
    output logic [NUM_CH-1:0]                           rx_valid,
    input  logic [NUM_CH-1:0]                           rx_ready,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    fifo_count,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    pkt_count,
    output logic [15:0]                                 drop_count,
    output logic [NUM_CH-1:0]                           fifo_full,
    output logic [NUM_CH-1:0]                           fifo_empty
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KW-1:0]         keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } ent_t;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] vld;
    logic              in_range;
    ent_t              wr_ent;
    logic [15:0]       drop_q;
    logic [15:0]       drop_d;

    assign wr_ent = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast,
                      user: s_axis_tuser};

    // A TID matching no channel is out of range; that beat is swallowed, so ready stays high.
    assign in_range      = |sel;
    assign s_axis_tready = in_range ? ~|(sel & full) : 1'b1;

    always_comb begin
        drop_d = drop_q;
        if (s_axis_tvalid && !in_range && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
    assign rx_valid   = vld;
    assign fifo_full  = full;
    assign fifo_empty = empty;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] wr_ptr_q;
        logic [PW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] pkt_q;
        logic [CW-1:0] pkt_d;
        logic          push_last;
        logic          pop_last;
        ent_t          mem_q [FIFO_DEPTH];
        ent_t          head;

        assign sel[c]   = (s_axis_tid == ID_WIDTH'(c));
        assign full[c]  = (cnt_q == CW'(FIFO_DEPTH));
        assign empty[c] = (cnt_q == '0);
        // Ready comes from the registered count, so a full channel cannot take a beat in
        // the same cycle it pops one.
        assign push[c]  = s_axis_tvalid & s_axis_tready & sel[c];
        assign head     = mem_q[rd_ptr_q];

`ifdef AXIS_SLV_PKT_MODE_EN
        // Hold the head until a whole packet is stored; a full FIFO releases it anyway so a
        // packet longer than the FIFO cannot wedge the channel.
        assign vld[c] = ~empty[c] & ((pkt_q != '0) | full[c]);
`else
        assign vld[c] = ~empty[c];
`endif

        assign pop[c]    = vld[c] & rx_ready[c];
        assign push_last = push[c] & s_axis_tlast;
        assign pop_last  = pop[c] & head.last;

        always_comb begin
            cnt_d = cnt_q;
            case ({push[c], pop[c]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_comb begin
            pkt_d = pkt_q;
            case ({push_last, pop_last})
                2'b10:   pkt_d = pkt_q + CW'(1);
                2'b01:   pkt_d = pkt_q - CW'(1);
                default: pkt_d = pkt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                pkt_q    <= '0;
            end else begin
                if (push[c]) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop[c])  rd_ptr_q <= rd_ptr_q + PW'(1);
                cnt_q <= cnt_d;
                pkt_q <= pkt_d;
            end
        end

        // Storage needs no reset: emptied pointers make old contents unreachable.
        always_ff @(posedge clk) begin
            if (push[c]) begin
                mem_q[wr_ptr_q] <= wr_ent;
            end
        end

        assign rx_data[c*DATA_WIDTH +: DATA_WIDTH] = head.data;
        assign rx_keep[c*KW +: KW]                 = head.keep;
        assign rx_last[c]                          = head.last;
        assign rx_user[c*USER_WIDTH +: USER_WIDTH] = head.user;
        assign fifo_count[c*CW +: CW]              = cnt_q;
        assign pkt_count[c*CW +: CW]               = pkt_q;
    end

endmodule

// File: tb/tb_axis_stream_slave_mc.sv
module tb_axis_stream_slave_mc;
    localparam int DW  = 128;
    localparam int UW  = 4;
    localparam int IW  = 4;
    localparam int NCH = 4;
    localparam int DEP = 16;
    localparam int KW  = DW / 8;
    localparam int CW  = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DW-1:0]       s_axis_tdata = '0;
    logic [KW-1:0]       s_axis_tkeep = '0;
    logic                s_axis_tlast = 1'b0;
    logic [UW-1:0]       s_axis_tuser = '0;
    logic [IW-1:0]       s_axis_tid = '0;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tready;
    logic [NCH*DW-1:0]   rx_data;
    logic [NCH*KW-1:0]   rx_keep;
    logic [NCH-1:0]      rx_last;
    logic [NCH*UW-1:0]   rx_user;
    logic [NCH-1:0]      rx_valid;
    logic [NCH-1:0]      rx_ready = '0;
    logic [NCH*CW-1:0]   fifo_count;
    logic [NCH*CW-1:0]   pkt_count;
    logic [15:0]         drop_count;
    logic [NCH-1:0]      fifo_full;
    logic [NCH-1:0]      fifo_empty;

    always #5 clk = ~clk;

    axis_stream_slave_mc #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW), .NUM_CH(NCH), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tid(s_axis_tid), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .rx_data(rx_data), .rx_keep(rx_keep), .rx_last(rx_last), .rx_user(rx_user),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .pkt_count(pkt_count), .drop_count(drop_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } ent_t;

    // Reference model: per-channel queue of stored beats plus a saturating drop tally.
    ent_t sb [NCH][$];
    int   drops_m  = 0;
    int   n_chk    = 0;
    int   n_err    = 0;
    bit   armed    = 1'b0;
    bit   taken    = 1'b0;
    bit   rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nlast(input int c);
        int n = 0;
        foreach (sb[c][i]) if (sb[c][i].l) n++;
        return n;
    endfunction

    function automatic bit exp_vld(input int c);
`ifdef AXIS_SLV_PKT_MODE_EN
        return (sb[c].size() != 0) && ((nlast(c) != 0) || (sb[c].size() == DEP));
`else
        return sb[c].size() != 0;
`endif
    endfunction

    function automatic bit exp_rdy();
        int idx = int'(s_axis_tid);
        if (idx < NCH) return sb[idx].size() < DEP;
        return 1'b1;
    endfunction

    function automatic int total();
        int n = 0;
        for (int c = 0; c < NCH; c++) n += sb[c].size();
        return n;
    endfunction

    // Monitor/scoreboard: compare every DUT output against the model, then advance the
    // model with the handshakes that the coming edge will complete.
    logic [NCH-1:0] ev;
    bit             er;
    always @(negedge clk) begin
        taken = 1'b0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) sb[c].delete();
            drops_m = 0;
            armed   = 1'b1;
        end else if (armed) begin
            er = exp_rdy();
            chk("tready", DW'(s_axis_tready), DW'(er));
            chk("drop_count", DW'(drop_count), DW'(drops_m));
            for (int c = 0; c < NCH; c++) begin
                ev[c] = exp_vld(c);
                chk($sformatf("rx_valid[%0d]", c), DW'(rx_valid[c]), DW'(ev[c]));
                chk($sformatf("fifo_count[%0d]", c), DW'(fifo_count[c*CW +: CW]), DW'(sb[c].size()));
                chk($sformatf("pkt_count[%0d]", c), DW'(pkt_count[c*CW +: CW]), DW'(nlast(c)));
                chk($sformatf("fifo_full[%0d]", c), DW'(fifo_full[c]), DW'(sb[c].size() == DEP));
                chk($sformatf("fifo_empty[%0d]", c), DW'(fifo_empty[c]), DW'(sb[c].size() == 0));
                if (sb[c].size() != 0) begin
                    chk($sformatf("rx_data[%0d]", c), rx_data[c*DW +: DW], sb[c][0].d);
                    chk($sformatf("rx_keep[%0d]", c), DW'(rx_keep[c*KW +: KW]), DW'(sb[c][0].k));
                    chk($sformatf("rx_last[%0d]", c), DW'(rx_last[c]), DW'(sb[c][0].l));
                    chk($sformatf("rx_user[%0d]", c), DW'(rx_user[c*UW +: UW]), DW'(sb[c][0].u));
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (ev[c] && rx_ready[c]) void'(sb[c].pop_front());
            end
            if (s_axis_tvalid && er) begin
                ent_t e;
                int   idx;
                taken = 1'b1;
                idx   = int'(s_axis_tid);
                e.d = s_axis_tdata; e.k = s_axis_tkeep; e.l = s_axis_tlast; e.u = s_axis_tuser;
                if (idx < NCH) sb[idx].push_back(e);
                else if (drops_m < 65535) drops_m++;
            end
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            rx_ready = NCH'($urandom);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send(input int tid, input logic [DW-1:0] d, input bit last);
        int t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tid    = IW'(tid);
        s_axis_tdata  = d;
        s_axis_tkeep  = KW'($urandom);
        s_axis_tlast  = last;
        s_axis_tuser  = UW'($urandom);
        do begin
            cyc(1);
            t++;
        end while (!taken && t < 300);
        n_chk++;
        if (!taken) begin
            n_err++;
            $display("FAIL send_timeout: tid %0d not accepted after %0d cycles, required within 300", tid, t);
        end
    endtask

    // Close any open packet on every channel, then pop everything.
    task automatic drain();
        int t = 0;
        rx_ready = '1;
        for (int c = 0; c < NCH; c++) send(c, DW'(32'hD000 + c), 1'b1);
        idle();
        while (total() != 0 && t < 200) begin
            cyc(1);
            t++;
        end
        cyc(1);
        chk("drain_empty", DW'(fifo_empty), DW'({NCH{1'b1}}));
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("reset_valid", DW'(rx_valid), DW'(0));
        chk("reset_empty", DW'(fifo_empty), DW'(4'hF));

        // Three beats into ch2, nothing popped.
        send(2, DW'(8'hA0), 1'b0);
        send(2, DW'(8'hA1), 1'b0);
        send(2, DW'(8'hA2), 1'b1);
        idle();
        cyc(1);
        chk("tp1_count", DW'(fifo_count[2*CW +: CW]), DW'(3));
        chk("tp1_pkt", DW'(pkt_count[2*CW +: CW]), DW'(1));
        chk("tp1_valid", DW'(rx_valid), DW'(4'b0100));
        chk("tp1_data", rx_data[2*DW +: DW], DW'(8'hA0));

        // Fill ch1, then a 17th beat stalls; switching to ch0 is accepted.
        for (int i = 0; i < DEP; i++) send(1, DW'(32'h1100 + i), (i % 5) == 4);
        s_axis_tid = IW'(1);
        cyc(3);
        chk("tp2_full", DW'(fifo_full[1]), DW'(1));
        chk("tp2_tready_lo", DW'(s_axis_tready), DW'(0));
        s_axis_tid = IW'(0);
        #1;
        chk("tp2_tready_hi", DW'(s_axis_tready), DW'(1));
        send(0, DW'(8'hC0), 1'b1);

        // Out-of-range TIDs.
        send(5, DW'(8'h55), 1'b0);
        send(15, DW'(8'hFF), 1'b1);
        idle();
        cyc(1);
        chk("tp3_drops", DW'(drop_count), DW'(2));
        chk("tp3_count1", DW'(fifo_count[1*CW +: CW]), DW'(DEP));
        drain();

        // Back-to-back through ch0 with the sink always ready, across pointer wrap.
        rx_ready = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            send(0, DW'(32'h2000 + i), (i % 7) == 6);
            if (i > 0) chk("tp4_count", DW'(fifo_count[0 +: CW]), DW'(1));
        end
        idle();
        cyc(2);
        chk("tp4_drained", DW'(fifo_count[0 +: CW]), DW'(0));

        // Random traffic with random per-channel readiness.
        rdy_rand = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                cyc($urandom_range(1, 3));
            end
            send($urandom_range(0, 6), {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) == 0);
        end
        idle();
        cyc(1);
        rdy_rand = 1'b0;
        cyc(1);
        drain();

        // Drop counter saturation.
        rx_ready      = '0;
        s_axis_tvalid = 1'b1;
        s_axis_tid    = IW'(15);
        cyc(65537);
        idle();
        cyc(1);
        chk("tp5_sat", DW'(drop_count), DW'(16'hFFFF));

        // Reset with beats queued on ch1.
        for (int i = 0; i < 5; i++) send(1, DW'(32'h3300 + i), 1'b0);
        idle();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("tp6_count1", DW'(fifo_count[1*CW +: CW]), DW'(0));
        chk("tp6_valid", DW'(rx_valid), DW'(0));
        chk("tp6_drops", DW'(drop_count), DW'(0));

`ifdef AXIS_SLV_PKT_MODE_EN
        rx_ready = '0;
        for (int i = 0; i < 3; i++) send(3, DW'(32'h4400 + i), 1'b0);
        idle();
        cyc(2);
        chk("tp7_hold", DW'(rx_valid[3]), DW'(0));
        send(3, DW'(32'h4403), 1'b1);
        idle();
        chk("tp7_release", DW'(rx_valid[3]), DW'(1));
        drain();
        rx_ready = '0;
        for (int i = 0; i < DEP; i++) send(3, DW'(32'h4500 + i), 1'b0);
        idle();
        chk("tp7_cut_through", DW'(rx_valid[3]), DW'(1));
        rx_ready = 4'b1000;
        for (int i = DEP; i < 20; i++) send(3, DW'(32'h4500 + i), 1'b0);
        idle();
        drain();
`endif

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
